// File: rtl/pwm_demod_pkg.sv
// pwm_demod_pkg: shared definitions for the PWM receive path.
//   - FSM state encoding (IDLE / MEASURE)
//   - frame-geometry helpers: FRAME = 2^w, HALF = 2^(w-1)
//   - signed saturation bounds for a w-bit recovered sample
package pwm_demod_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam int DEF_WIDTH = 12;

  function automatic int frame_len(input int w);
    return 1 << w;
  endfunction

  function automatic int half_len(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/pwm_sync2.sv
// pwm_sync2: two-flop synchronizer for an asynchronous PMOD input.
//   clk   - destination clock
//   reset - asynchronous active-high, clears both flops to 0
//   d     - asynchronous input
//   q     - synchronized output (two clocks of latency)
module pwm_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod: recovers signed samples from an offset-binary PWM stream whose
// frame is 2^width clocks long (high time = sample + 2^(width-1)).
//   clk          - system clock
//   reset        - asynchronous active-high, clears all state
//   pwm_in       - asynchronous PWM input pin
//   sample       - signed recovered sample, holds between updates
//   sample_valid - one-cycle pulse when sample updates
//   period_err   - one-cycle pulse when a frame length is out of tolerance
//   locked       - set after LOCK_FRAMES consecutive good frames
// Pipeline: sync (2 flops) -> edge flop -> frame close (stage 1) -> outputs
// (stage 2), so a pwm_in rise sampled at edge E produces outputs at E+3.
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int width       = DEF_WIDTH,
  parameter int TOL         = 4,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pwm_in,
  output logic signed [width-1:0] sample,
  output logic                    sample_valid,
  output logic                    period_err,
  output logic                    locked
);

  localparam int CW    = width + 1;
  localparam int FRAME = frame_len(width);
  localparam int HALF  = half_len(width);
  localparam int GW    = $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0] PER_MIN = CW'(FRAME - TOL);
  localparam logic [CW-1:0] PER_MAX = CW'(FRAME + TOL);
  localparam logic [CW-1:0] PER_TO  = CW'(FRAME + TOL + 1);

  localparam logic signed [width-1:0] S_MAX  = width'(sat_max(width));
  localparam logic signed [width-1:0] S_MIN  = width'(sat_min(width));
  localparam logic signed [CW:0]      D_MAX  = (CW+1)'(sat_max(width));
  localparam logic signed [CW:0]      D_MIN  = (CW+1)'(sat_min(width));
  localparam logic signed [CW:0]      D_HALF = (CW+1)'(HALF);

  // ---- input conditioning
  logic s2, s3, rise;

  pwm_sync2 u_sync (.clk(clk), .reset(reset), .d(pwm_in), .q(s2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s3 <= 1'b0;
    else       s3 <= s2;
  end

  assign rise = s2 & ~s3;

  // ---- stage 1: frame measurement and close
  logic [0:0]    state;
  logic [CW-1:0] per_cnt, hi_cnt;
  logic          cl_ok, cl_err, cl_to, cl_lvl;
  logic [CW-1:0] cl_hi;
  logic          in_tol;

  assign in_tol = (per_cnt >= PER_MIN) && (per_cnt <= PER_MAX);

  // A restart always counts the current cycle as cycle 1 of the new frame,
  // so an edge-closed frame reports exactly the clocks between edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      cl_ok   <= 1'b0;
      cl_err  <= 1'b0;
      cl_to   <= 1'b0;
      cl_lvl  <= 1'b0;
      cl_hi   <= '0;
    end else begin
      cl_ok  <= 1'b0;
      cl_err <= 1'b0;
      cl_to  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Partial frame before the first edge is thrown away.
          if (rise) begin
            state   <= ST_MEASURE;
            per_cnt <= CW'(1);
            hi_cnt  <= CW'(1);
          end
        end
        default: begin
          if (rise) begin
            // Edge beats a coincident timeout.
            if (in_tol) begin
              cl_ok <= 1'b1;
              cl_hi <= hi_cnt;
            end else begin
              cl_err <= 1'b1;
            end
            per_cnt <= CW'(1);
            hi_cnt  <= CW'(1);
          end else if (per_cnt == PER_TO) begin
            // No edge: a 0% or 100% frame, judged by the current level.
            cl_to   <= 1'b1;
            cl_lvl  <= s2;
            per_cnt <= CW'(1);
            hi_cnt  <= {{width{1'b0}}, s2};
          end else begin
            per_cnt <= per_cnt + 1'b1;
            hi_cnt  <= hi_cnt + {{width{1'b0}}, s2};
          end
        end
      endcase
    end
  end

  // ---- stage 2: offset removal, saturation, lock tracking
  logic signed [CW:0]      diff;
  logic signed [width-1:0] sat_val;
  logic [GW-1:0]           good_cnt;

  assign diff = $signed({1'b0, cl_hi}) - D_HALF;

  always_comb begin
    sat_val = diff[width-1:0];
    if (diff > D_MAX)      sat_val = S_MAX;
    else if (diff < D_MIN) sat_val = S_MIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      period_err   <= 1'b0;
      good_cnt     <= '0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= cl_ok | cl_to;
      period_err   <= cl_err;
      if (cl_ok)      sample <= sat_val;
      else if (cl_to) sample <= cl_lvl ? S_MAX : S_MIN;
      if (cl_ok | cl_to) begin
        if (good_cnt >= GW'(LOCK_FRAMES - 1)) locked <= 1'b1;
        if (good_cnt != GW'(LOCK_FRAMES))     good_cnt <= good_cnt + 1'b1;
      end else if (cl_err) begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: drives PWM frames into pwm_demod (width 8: 256-clock frames)
// and checks every sample_valid / period_err pulse against a scoreboard of
// expected results queued as each frame is driven.
module tb_pwm_demod;

  localparam int W   = 8;
  localparam int TOL = 4;
  localparam int LF  = 4;
  localparam int NV  = 21;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                pwm_in = 1'b0;
  logic signed [W-1:0] sample;
  logic                sample_valid, period_err, locked;

  pwm_demod #(.width(W), .TOL(TOL), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .sample(sample), .sample_valid(sample_valid),
    .period_err(period_err), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {int per; int hi; bit err; int smp; bit lk;} vec_t;
  typedef struct {bit err; int smp; bit lk; bit lat; int gap;} exp_t;

  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, rise_cyc = 0, last_v_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit err, input int smp, input bit lk, input bit lat, input int gap);
    exp_t e;
    e.err = err; e.smp = smp; e.lk = lk; e.lat = lat; e.gap = gap;
    sb.push_back(e);
  endtask

  // One frame: high for hi clocks, then low, total per clocks.
  task automatic drive_frame(input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      pwm_in = (i < hi);
      if (i == 0 && hi > 0) rise_cyc = cyc;
    end
  endtask

  // Output monitor / scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (sample_valid || period_err)) begin
      chk("valid_err_exclusive", int'(sample_valid && period_err), 0);
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("period_err", int'(period_err), int'(e.err));
        chk("sample_valid", int'(sample_valid), int'(!e.err));
        chk("sample", int'(sample), e.smp);
        chk("locked", int'(locked), int'(e.lk));
        if (e.lat)     chk("latency", cyc - rise_cyc, 4);
        if (e.gap > 0) chk("valid_spacing", cyc - last_v_cyc, e.gap);
      end
      if (sample_valid) last_v_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[NV];
    tbl = '{
      '{256, 128, 0,    0, 0},   // lock build-up
      '{256, 128, 0,    0, 0},
      '{256, 128, 0,    0, 0},
      '{256, 128, 0,    0, 1},   // 4th good frame locks
      '{256,  32, 0,  -96, 1},   // duty sweep
      '{256,  64, 0,  -64, 1},
      '{256,  96, 0,  -32, 1},
      '{256, 160, 0,   32, 1},
      '{256, 192, 0,   64, 1},
      '{256, 224, 0,   96, 1},
      '{257, 256, 0,  127, 1},   // hi = FRAME saturates
      '{256,   1, 0, -127, 1},
      '{252, 100, 0,  -28, 1},   // FRAME-TOL accepted
      '{260, 200, 0,   72, 1},   // FRAME+TOL accepted
      '{251, 125, 1,   72, 0},   // just short: error, sample held
      '{256, 128, 0,    0, 0},
      '{261, 128, 1,    0, 0},   // edge coincides with timeout: edge wins
      '{256, 128, 0,    0, 0},   // re-lock
      '{256, 128, 0,    0, 0},
      '{256, 128, 0,    0, 0},
      '{256, 128, 0,    0, 1}
    };

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sample", int'(sample), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_period_err", int'(period_err), 0);
    chk("rst_locked", int'(locked), 0);
    @(negedge clk) reset = 1'b0;
    repeat (100) @(negedge clk);

    // table vectors; each result emerges at the next frame's rising edge
    for (int v = 0; v < NV; v++) begin
      push(tbl[v].err, tbl[v].smp, tbl[v].lk, 1'b1, 0);
      drive_frame(tbl[v].per, tbl[v].hi);
    end

    // held low: three timeouts at -max, then an edge-closed all-low frame
    push(0, -128, 1, 0, 261);
    push(0, -128, 1, 0, 261);
    push(0, -128, 1, 0, 261);
    push(0, -128, 1, 1, 256);
    drive_frame(3*261 + 256, 10);

    // held high: two timeouts at +max, then a 200-high frame closed by edge
    push(0, 127, 1, 0, 261);
    push(0, 127, 1, 0, 261);
    push(0,  72, 1, 1, 256);
    drive_frame(2*261 + 256, 2*261 + 200);

    // reset mid-frame, asserted away from any clock edge
    drive_frame(128, 128);
    #2 reset = 1'b1;
    #1;
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_sample_valid", int'(sample_valid), 0);
    @(negedge clk) pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // first post-reset edge only starts measurement
    push(0,   0, 0, 1, 0);
    drive_frame(256, 128);
    push(0, -64, 0, 1, 256);
    drive_frame(256, 64);
    drive_frame(50, 10);
    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
